// File: rtl/i2c_master.sv
// Byte-level single-master I2C controller: START, repeated START, STOP, byte write and byte read.
// Open-drain pins: a driver output of 1 pulls the line low.
module i2c_master #(
  parameter int unsigned QUARTER = 120
) (
  input  logic       clk6x,
  input  logic       resetn,
  input  logic [1:0] cmd_i,
  input  logic       cmd_v_i,
  output logic       cmd_ready_o,
  input  logic [7:0] txbyte_i,
  input  logic       ack_i,
  output logic [7:0] rxbyte_o,
  output logic       nack_o,
  output logic       done_o,
  output logic       busy_o,
  input  logic       I2C_SCL_i,
  output logic       I2C_SCLDR0_o,
  input  logic       I2C_SDA_i,
  output logic       I2C_SDADR0_o
);

  typedef enum logic [2:0] {StIdle, StStart, StWrite, StRead, StStop} state_e;

  localparam logic [1:0]  CmdStart = 2'd0;
  localparam logic [1:0]  CmdWrite = 2'd1;
  localparam logic [1:0]  CmdRead  = 2'd2;
  localparam logic [1:0]  CmdStop  = 2'd3;
  localparam logic [15:0] QLast    = 16'(QUARTER - 1);

  state_e      state_q, state_d;
  logic [1:0]  qtr_q, qtr_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  bit_q, bit_d;
  logic [7:0]  sh_q, sh_d;
  logic        ack_q, ack_d;
  logic        scl_dr_q, scl_dr_d;
  logic        sda_dr_q, sda_dr_d;
  logic        ready_q, ready_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic        nack_q, nack_d;
  logic [7:0]  rx_q, rx_d;
  logic        scl_meta_q, scl_s_q, sda_meta_q, sda_s_q;

  logic accept, adv, qend, last_bit, bit_end, cmd_end, sample, illegal;

  assign accept   = cmd_v_i && ready_q;
  // The first Q1 cycle always counts: the SCL release is not yet visible through the synchronizer.
  assign adv      = (qtr_q != 2'd1) || scl_s_q || (cnt_q == 16'd0);
  assign qend     = adv && (cnt_q == QLast);
  assign last_bit = (state_q == StStart) || (state_q == StStop) || (bit_q == 4'd8);
  assign bit_end  = (state_q != StIdle) && qend && (qtr_q == 2'd3);
  assign cmd_end  = bit_end && last_bit;
  assign sample   = (qtr_q == 2'd2) && (cnt_q == QLast);
  assign illegal  = accept && (cmd_i != CmdStart) && !busy_q;

  always_ff @(posedge clk6x) begin
    if (!resetn) begin
      state_q    <= StIdle;
      qtr_q      <= 2'd0;
      cnt_q      <= 16'd0;
      bit_q      <= 4'd0;
      sh_q       <= 8'h00;
      ack_q      <= 1'b0;
      scl_dr_q   <= 1'b0;
      sda_dr_q   <= 1'b0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      nack_q     <= 1'b0;
      rx_q       <= 8'h00;
      scl_meta_q <= 1'b1;
      scl_s_q    <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_s_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      qtr_q      <= qtr_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      sh_q       <= sh_d;
      ack_q      <= ack_d;
      scl_dr_q   <= scl_dr_d;
      sda_dr_q   <= sda_dr_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      nack_q     <= nack_d;
      rx_q       <= rx_d;
      scl_meta_q <= I2C_SCL_i;
      scl_s_q    <= scl_meta_q;
      sda_meta_q <= I2C_SDA_i;
      sda_s_q    <= sda_meta_q;
    end
  end

  always_comb begin
    state_d = state_q;
    qtr_d   = qtr_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    if (state_q == StIdle) begin
      qtr_d = 2'd0;
      cnt_d = 16'd0;
      bit_d = 4'd0;
      if (accept) begin
        case (cmd_i)
          CmdStart: state_d = StStart;
          CmdWrite: if (busy_q) state_d = StWrite;
          CmdRead:  if (busy_q) state_d = StRead;
          CmdStop:  if (busy_q) state_d = StStop;
          default:  state_d = StIdle;
        endcase
      end
    end else if (qend) begin
      cnt_d = 16'd0;
      qtr_d = qtr_q + 2'd1;
      if (qtr_q == 2'd3) begin
        if (last_bit) state_d = StIdle;
        else          bit_d   = bit_q + 4'd1;
      end
    end else if (adv) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_comb begin
    scl_dr_d = scl_dr_q;
    sda_dr_d = sda_dr_q;
    sh_d     = sh_q;
    ack_d    = ack_q;
    busy_d   = busy_q;
    nack_d   = nack_q;
    rx_d     = rx_q;
    ready_d  = (state_d == StIdle);
    done_d   = cmd_end || illegal;
    if (illegal) nack_d = 1'b1;
    case (state_q)
      StIdle: begin
        // While the bus is owned, SCL is parked low and SDA keeps its last level.
        scl_dr_d = busy_q;
        sda_dr_d = busy_q && sda_dr_q;
        if (accept) begin
          sh_d  = txbyte_i;
          ack_d = ack_i;
        end
      end
      StStart: begin
        case (qtr_q)
          2'd0:    sda_dr_d = 1'b0;
          2'd1:    scl_dr_d = 1'b0;
          2'd2:    sda_dr_d = 1'b1;
          default: scl_dr_d = 1'b1;
        endcase
        if (cmd_end) busy_d = 1'b1;
      end
      StWrite: begin
        case (qtr_q)
          2'd0:    sda_dr_d = (bit_q == 4'd8) ? 1'b0 : ~sh_q[7];
          2'd1:    scl_dr_d = 1'b0;
          2'd2:    scl_dr_d = 1'b0;
          default: scl_dr_d = 1'b1;
        endcase
        if (sample && bit_q == 4'd8) nack_d = sda_s_q;
        if (bit_end && bit_q != 4'd8) sh_d = {sh_q[6:0], 1'b0};
      end
      StRead: begin
        case (qtr_q)
          2'd0:    sda_dr_d = (bit_q == 4'd8) ? ack_q : 1'b0;
          2'd1:    scl_dr_d = 1'b0;
          2'd2:    scl_dr_d = 1'b0;
          default: scl_dr_d = 1'b1;
        endcase
        if (sample && bit_q != 4'd8) sh_d = {sh_q[6:0], sda_s_q};
        if (cmd_end) rx_d = sh_q;
      end
      StStop: begin
        case (qtr_q)
          2'd0:    sda_dr_d = 1'b1;
          2'd1:    scl_dr_d = 1'b0;
          2'd2:    sda_dr_d = 1'b0;
          default: sda_dr_d = 1'b0;
        endcase
        if (cmd_end) busy_d = 1'b0;
      end
      default: begin
        scl_dr_d = 1'b0;
        sda_dr_d = 1'b0;
      end
    endcase
  end

  assign cmd_ready_o  = ready_q;
  assign done_o       = done_q;
  assign busy_o       = busy_q;
  assign nack_o       = nack_q;
  assign rxbyte_o     = rx_q;
  assign I2C_SCLDR0_o = scl_dr_q;
  assign I2C_SDADR0_o = sda_dr_q;

endmodule

// File: tb/tb_i2c_master.sv
// Directed bench for i2c_master with QUARTER=4: open-drain bus with a small slave model,
// a START/STOP and bit monitor, and latency measurements against hand-computed cycle counts.
module tb_i2c_master;
  localparam int unsigned Q = 4;

  logic       clk6x = 1'b0;
  logic       resetn = 1'b0;
  logic [1:0] cmd_i = 2'd0;
  logic       cmd_v_i = 1'b0;
  logic       cmd_ready_o;
  logic [7:0] txbyte_i = 8'h00;
  logic       ack_i = 1'b0;
  logic [7:0] rxbyte_o;
  logic       nack_o, done_o, busy_o;
  logic       I2C_SCLDR0_o, I2C_SDADR0_o;
  logic       scl_line, sda_line;

  logic       slave_scl_low = 1'b0;
  logic       slave_sda_low = 1'b0;
  int         slave_mode = 0;  // 0 = absent, 1 = ACK writes, 2 = send rd_byte
  logic [7:0] rd_byte = 8'h00;
  logic       stretch_en = 1'b0;
  int         nfall = 0;

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int t0 = 0;
  int lat;
  int start_cnt = 0;
  int stop_cnt = 0;
  int drv_ev = 0;
  int snap_a, snap_b;
  logic bits_q[$];
  logic mdr_q[$];

  assign scl_line = ~(I2C_SCLDR0_o | slave_scl_low);
  assign sda_line = ~(I2C_SDADR0_o | slave_sda_low);

  i2c_master #(.QUARTER(Q)) u_dut (
    .clk6x        (clk6x),
    .resetn       (resetn),
    .cmd_i        (cmd_i),
    .cmd_v_i      (cmd_v_i),
    .cmd_ready_o  (cmd_ready_o),
    .txbyte_i     (txbyte_i),
    .ack_i        (ack_i),
    .rxbyte_o     (rxbyte_o),
    .nack_o       (nack_o),
    .done_o       (done_o),
    .busy_o       (busy_o),
    .I2C_SCL_i    (scl_line),
    .I2C_SCLDR0_o (I2C_SCLDR0_o),
    .I2C_SDA_i    (sda_line),
    .I2C_SDADR0_o (I2C_SDADR0_o)
  );

  always #5 clk6x = ~clk6x;
  always @(posedge clk6x) cyc <= cyc + 1;

  always @(posedge scl_line) begin
    bits_q.push_back(sda_line);
    mdr_q.push_back(I2C_SDADR0_o);
  end
  always @(negedge sda_line) if (scl_line === 1'b1) start_cnt = start_cnt + 1;
  always @(posedge sda_line) if (scl_line === 1'b1) stop_cnt = stop_cnt + 1;
  always @(I2C_SCLDR0_o, I2C_SDADR0_o) drv_ev = drv_ev + 1;

  always @(negedge scl_line) begin
    nfall = nfall + 1;
    if (slave_mode == 1) slave_sda_low = (nfall == 8);
    else if (slave_mode == 2) slave_sda_low = (nfall < 8) ? ~rd_byte[7 - nfall] : 1'b0;
    if (stretch_en && nfall == 3) slave_scl_low = 1'b1;
  end

  // Hold SCL low for 50 cycles beyond the master's own release.
  always @(negedge I2C_SCLDR0_o) begin
    if (slave_scl_low) begin
      repeat (50) @(posedge clk6x);
      #1;
      slave_scl_low = 1'b0;
      stretch_en = 1'b0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [1:0] c, input logic [7:0] b, input logic a);
    @(negedge clk6x);
    check_eq("ready_at_issue", {31'd0, cmd_ready_o}, 32'd1);
    cmd_i = c;
    txbyte_i = b;
    ack_i = a;
    cmd_v_i = 1'b1;
    nfall = 0;
    @(posedge clk6x);
    #1;
    cmd_v_i = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done(input string tag, output int l);
    l = -1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk6x);
      if (done_o) begin
        l = cyc - t0;
        break;
      end
    end
    check_eq({tag, "_done_seen"}, (l >= 0) ? 32'd1 : 32'd0, 32'd1);
  endtask

  function automatic logic [7:0] first_byte();
    logic [7:0] b;
    b = 8'h00;
    for (int i = 0; i < 8; i++) if (i < bits_q.size()) b = {b[6:0], bits_q[i]};
    return b;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    repeat (3) @(posedge clk6x);
    @(negedge clk6x);
    resetn = 1'b1;
    repeat (3) @(negedge clk6x);
    check_eq("rst_ready", {31'd0, cmd_ready_o}, 32'd1);
    check_eq("rst_busy", {31'd0, busy_o}, 32'd0);
    check_eq("rst_done", {31'd0, done_o}, 32'd0);
    check_eq("rst_nack", {31'd0, nack_o}, 32'd0);
    check_eq("rst_rx", {24'd0, rxbyte_o}, 32'h00);
    check_eq("rst_scldr", {31'd0, I2C_SCLDR0_o}, 32'd0);
    check_eq("rst_sdadr", {31'd0, I2C_SDADR0_o}, 32'd0);
    start_cnt = 0;
    stop_cnt = 0;

    // START then WRITE 0x84 to an ACKing slave
    send(2'd0, 8'h00, 1'b0);
    wait_done("start1", lat);
    check_eq("start1_cond", start_cnt, 1);
    check_eq("start1_busy", {31'd0, busy_o}, 32'd1);
    slave_mode = 1;
    bits_q.delete();
    mdr_q.delete();
    send(2'd1, 8'h84, 1'b0);
    wait_done("wr84", lat);
    check_eq("wr84_latency", lat, 162);
    check_eq("wr84_nack", {31'd0, nack_o}, 32'd0);
    check_eq("wr84_busy", {31'd0, busy_o}, 32'd1);
    check_eq("wr84_rises", bits_q.size(), 9);
    check_eq("wr84_bits", {24'd0, first_byte()}, 32'h84);
    if (bits_q.size() == 9) check_eq("wr84_ackbit", {31'd0, bits_q[8]}, 32'd0);
    check_eq("wr84_scl_held", {31'd0, I2C_SCLDR0_o}, 32'd1);

    // WRITE with no slave: NACK, bus stays owned
    slave_mode = 0;
    send(2'd1, 8'h5A, 1'b0);
    wait_done("wr5a", lat);
    check_eq("wr5a_latency", lat, 162);
    check_eq("wr5a_nack", {31'd0, nack_o}, 32'd1);
    check_eq("wr5a_busy", {31'd0, busy_o}, 32'd1);

    // READ with NACK, slave returns 0xA5
    slave_mode = 2;
    rd_byte = 8'hA5;
    @(negedge clk6x);
    slave_sda_low = ~rd_byte[7];
    bits_q.delete();
    mdr_q.delete();
    send(2'd2, 8'h00, 1'b0);
    wait_done("rd", lat);
    check_eq("rd_latency", lat, 162);
    check_eq("rd_byte", {24'd0, rxbyte_o}, 32'hA5);
    check_eq("rd_rises", bits_q.size(), 9);
    check_eq("rd_bus_bits", {24'd0, first_byte()}, 32'hA5);
    if (mdr_q.size() == 9) begin
      check_eq("rd_nack_bit_line", {31'd0, bits_q[8]}, 32'd1);
      check_eq("rd_nack_bit_drv", {31'd0, mdr_q[8]}, 32'd0);
    end
    slave_mode = 0;
    slave_sda_low = 1'b0;

    // STOP
    snap_a = stop_cnt;
    send(2'd3, 8'h00, 1'b0);
    wait_done("stop", lat);
    check_eq("stop_cond", stop_cnt - snap_a, 1);
    check_eq("stop_busy", {31'd0, busy_o}, 32'd0);
    @(negedge clk6x);
    check_eq("stop_scl_rel", {31'd0, I2C_SCLDR0_o}, 32'd0);
    check_eq("stop_sda_rel", {31'd0, I2C_SDADR0_o}, 32'd0);

    // Clock stretch of 50 cycles in bit 3 of WRITE 0x3C, then repeated START
    snap_a = start_cnt;
    snap_b = stop_cnt;
    send(2'd0, 8'h00, 1'b0);
    wait_done("start2", lat);
    slave_mode = 1;
    stretch_en = 1'b1;
    bits_q.delete();
    send(2'd1, 8'h3C, 1'b0);
    wait_done("wr3c", lat);
    check_eq("wr3c_latency", lat, 162 + 50);
    check_eq("wr3c_bits", {24'd0, first_byte()}, 32'h3C);
    check_eq("wr3c_nack", {31'd0, nack_o}, 32'd0);
    slave_mode = 0;
    send(2'd0, 8'h00, 1'b0);
    wait_done("rstart", lat);
    check_eq("rstart_starts", start_cnt - snap_a, 2);
    check_eq("rstart_no_stop", stop_cnt - snap_b, 0);
    check_eq("rstart_busy", {31'd0, busy_o}, 32'd1);
    send(2'd3, 8'h00, 1'b0);
    wait_done("stop2", lat);
    check_eq("stop2_busy", {31'd0, busy_o}, 32'd0);

    // Illegal WRITE while the bus is free
    check_eq("ill_pre_nack", {31'd0, nack_o}, 32'd0);
    snap_a = drv_ev;
    send(2'd1, 8'hFF, 1'b0);
    wait_done("ill", lat);
    check_eq("ill_latency", lat, 0);
    check_eq("ill_nack", {31'd0, nack_o}, 32'd1);
    check_eq("ill_ready", {31'd0, cmd_ready_o}, 32'd1);
    repeat (5) @(negedge clk6x);
    check_eq("ill_no_pins", drv_ev - snap_a, 0);

    // Reset in the middle of a byte
    send(2'd0, 8'h00, 1'b0);
    wait_done("start3", lat);
    send(2'd1, 8'h00, 1'b0);
    lat = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk6x);
      if (I2C_SCLDR0_o && I2C_SDADR0_o) begin
        lat = i;
        break;
      end
    end
    check_eq("midrst_both_driven", (lat >= 0) ? 32'd1 : 32'd0, 32'd1);
    resetn = 1'b0;
    @(posedge clk6x);
    #1;
    check_eq("midrst_scldr", {31'd0, I2C_SCLDR0_o}, 32'd0);
    check_eq("midrst_sdadr", {31'd0, I2C_SDADR0_o}, 32'd0);
    @(negedge clk6x);
    resetn = 1'b1;
    @(negedge clk6x);
    check_eq("midrst_busy", {31'd0, busy_o}, 32'd0);
    check_eq("midrst_ready", {31'd0, cmd_ready_o}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_master.md
# i2c_master

Byte-level I2C bus master for NORA, the counterpart of the SMC's I2C slave. It generates START, repeated START, STOP, 8-bit writes with ACK sampling, and 8-bit reads with ACK/NACK, using open-drain SCL/SDA drivers. Slave clock stretching is supported. It runs on clk6x (48 MHz) and is driven by a simple command/strobe interface from the CPU-facing register block. Single-master only: no arbitration.

## Interface
- QUARTER, 120: clk6x cycles per SCL quarter-phase. Nominal SCL period is 4*QUARTER, which gives 100 kHz at 48 MHz. Must be ≥ 3.
- clk6x  in  1  system clock, 48 MHz
- resetn  in  1  reset, synchronous, active-low, clock clk6x
- cmd_i  in  2  command: 0=START, 1=WRITE, 2=READ, 3=STOP
- cmd_v_i  in  1  command strobe; accepted only when cmd_ready_o=1
- cmd_ready_o  out  1  1 in IDLE only
- txbyte_i  in  8  byte for WRITE; captured at acceptance
- ack_i  in  1  for READ: 1 = master ACKs, 0 = master NACKs; captured at acceptance
- rxbyte_o  out  8  last byte read; updated when a READ completes
- nack_o  out  1  status of the last WRITE: 1 = slave NACKed, or an illegal command was issued
- done_o  out  1  1-cycle pulse when a command completes
- busy_o  out  1  bus owned: set by START, cleared by STOP
- I2C_SCL_i  in  1  SCL pin level
- I2C_SCLDR0_o  out  1  1 = drive SCL low
- I2C_SDA_i  in  1  SDA pin level
- I2C_SDADR0_o  out  1  1 = drive SDA low

## Operation
- I2C_SCL_i and I2C_SDA_i each pass through a 2-FF synchronizer (scl_s, sda_s) before use.
- A 16-bit quarter counter runs from 0 to QUARTER-1. Each bit-time has four quarters, Q0 to Q3.
- Clock stretching: in Q1 the counter increments only while scl_s=1, so a slave holding SCL low extends Q1 without limit.
- All pin drivers and outputs are registered.
- States and pin drive per quarter:
  - IDLE:
    - SCL driven low if busy_o=1, otherwise released.
    - SDA released, except that it stays low after a STOP has not been issued.
  - START:
    - Q0: release SDA.
    - Q1: release SCL, wait for it to go high.
    - Q2: drive SDA low.
    - Q3: drive SCL low.
    - Then set busy_o=1 and go to IDLE.
    - Issued while busy_o=1, this produces a repeated START.
  - WRITE, bits 7..0 MSB first, then the ACK bit:
    - Q0: set SDA (drive low for a 0, release for a 1).
    - Q1: release SCL.
    - Q2: SCL high.
    - Q3: drive SCL low.
    - ACK bit: SDA released; sda_s sampled on the last cycle of Q2; nack_o = the sampled value.
  - READ, 8 data bits then the ACK bit:
    - Data bits: SDA released; sda_s sampled on the last cycle of Q2 and shifted in MSB first.
    - ACK bit: SDA driven low if ack_i=1, otherwise released.
    - rxbyte_o is loaded at completion.
  - STOP:
    - Q0: drive SDA low.
    - Q1: release SCL, wait for it to go high.
    - Q2: release SDA.
    - Q3: idle quarter.
    - Then busy_o=0.
- Illegal commands: WRITE, READ or STOP while busy_o=0 causes no bus activity. done_o pulses on the next cycle and nack_o=1.
- cmd_v_i while cmd_ready_o=0 is ignored, not queued.
- Reset values: cmd_ready_o=1, done_o=0, busy_o=0, nack_o=0, rxbyte_o=8'h00, both drivers = 0 (released). State goes to IDLE.
- Reset mid-operation: both lines are released on the next clock and no STOP is generated. Bus recovery is left to software.

## Timing
- Acceptance: cmd_ready_o falls on the cycle after the accepting edge.
- First pin change: occurs on the cycle after cmd_ready_o falls.
- Quarter length: QUARTER cycles, except Q1, which lasts QUARTER+2 cycles with no stretching (2 cycles of synchronizer latency) plus any stretch time.
- Bit-time: 4*QUARTER+2 cycles without stretching.
- START and STOP each take one bit-time.
- WRITE and READ each take 9 bit-times.
- done_o: asserted 1 cycle after the last Q3 cycle; cmd_ready_o=1 in the same cycle.
- Status outputs: rxbyte_o, nack_o and busy_o are valid in the done_o cycle and held until the next completion.
- SDA changes only in Q0 or Q2. During data bits it changes only while SCL is low.

## Test plan
- Reset: pulse resetn low, then hold for 3 cycles. Require cmd_ready_o=1, busy_o=0, done_o=0, nack_o=0, rxbyte_o=0x00, both drivers 0.
- START + WRITE 0x84 to an ACKing slave model (QUARTER=4, pull-up instantaneous):
  - SDA falls while SCL is high.
  - Bits on SCL rising edges are 1,0,0,0,0,1,0,0.
  - done_o occurs 162 cycles after WRITE acceptance; nack_o=0; busy_o=1.
- WRITE with no slave (SDA floating high): nack_o=1 at done_o; the bus stays owned.
- READ, ack_i=0, slave returns 0xA5, then STOP:
  - rxbyte_o=0xA5; SDA is released during the 9th bit.
  - STOP: SDA rises while SCL is high; busy_o=0 after done_o.
- Clock stretching: the slave holds SCL low for 50 cycles in bit 3 of a WRITE 0x3C. The byte is received intact and done_o arrives exactly 50 cycles later than without stretching.
- Repeated START and error cases:
  - START, WRITE, START: the second START produces an SDA fall with SCL high and no STOP in between; busy_o stays 1.
  - WRITE issued while busy_o=0: done_o after 1 cycle, nack_o=1, no pin activity.
  - resetn asserted in the middle of a byte: both drivers 0 on the next cycle.
